// File: rtl/rl_lr_pmem_sched.sv
// Particle-memory load sequencer: round-robin, packet-locked sharing of the
// RL->LR bridge write port between NREQ ring requesters.
module rl_lr_pmem_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAXNUMP = 1024,
  parameter int unsigned PADDRW  = $clog2(MAXNUMP),
  parameter int unsigned PDATAW  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   xfer_done,
  output logic                   ovf_err,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*PADDRW-1:0] req_addr,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*PDATAW-1:0] req_wdata,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   pvalid,
  output logic [PADDRW-1:0]      paddr,
  output logic                   pwe,
  output logic [PDATAW-1:0]      pwdata,
  output logic                   plast,
  input  logic                   pready
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = PADDRW + 1;
  localparam logic [CW-1:0] MaxCnt = CW'(MAXNUMP);

  typedef enum logic [1:0] {StIdle, StArb, StXfer, StDone} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] done_mask_q, done_mask_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            ovf_err_q, ovf_err_d;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] gnt_oh;
  logic [GW-1:0]   pick;
  logic            pick_found;
  logic            beat;
  logic            pkt_end;
  logic            all_done_after;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] idx);
    if (32'(idx) >= NREQ - 1) return '0;
    return idx + GW'(1);
  endfunction

  assign cand           = req_valid & ~done_mask_q;
  assign gnt_oh         = NREQ'(1) << gnt_q;
  assign all_done_after = &(done_mask_q | gnt_oh);
  assign beat           = (state_q == StXfer) && req_valid[gnt_q] && pready;
  assign pkt_end        = beat && req_last[gnt_q];
  assign ovf_err        = ovf_err_q;

  // First candidate at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [GW-1:0] idx;
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    idx        = rr_ptr_q;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!pick_found && cand[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StArb;
      StArb: begin
        if (&done_mask_q)    state_d = StDone;
        else if (pick_found) state_d = StXfer;
      end
      StXfer: begin
        if (pkt_end) state_d = all_done_after ? StDone : StArb;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant, pointer, completion mask and beat accounting.
  always_comb begin
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    done_mask_d = done_mask_q;
    beat_cnt_d  = beat_cnt_q;
    ovf_err_d   = ovf_err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          done_mask_d = '0;
          beat_cnt_d  = '0;
          ovf_err_d   = 1'b0;
        end
      end
      StArb: begin
        if (!(&done_mask_q) && pick_found) gnt_d = pick;
      end
      StXfer: begin
        if (beat) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + CW'(1);
          // This beat makes the count MAXNUMP+1 or more; it is still forwarded.
          if (beat_cnt_q >= MaxCnt) ovf_err_d = 1'b1;
          if (pkt_end) begin
            done_mask_d = done_mask_q | gnt_oh;
            rr_ptr_d    = wrap_inc(gnt_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      done_mask_q <= '0;
      beat_cnt_q  <= '0;
      ovf_err_q   <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      done_mask_q <= done_mask_d;
      beat_cnt_q  <= beat_cnt_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  // Outputs: the granted slice passes straight through while in XFER.
  always_comb begin
    busy      = (state_q == StArb) || (state_q == StXfer);
    xfer_done = (state_q == StDone);
    pvalid    = 1'b0;
    paddr     = '0;
    pwe       = 1'b0;
    pwdata    = '0;
    plast     = 1'b0;
    req_ready = '0;
    if (state_q == StXfer) begin
      pvalid    = req_valid[gnt_q];
      paddr     = req_addr[32'(gnt_q)*PADDRW +: PADDRW];
      pwe       = req_we[gnt_q];
      pwdata    = req_wdata[32'(gnt_q)*PDATAW +: PDATAW];
      req_ready = pready ? gnt_oh : '0;
      // Only the final packet's last beat closes the whole phase.
      plast     = req_last[gnt_q] && all_done_after;
    end
  end

endmodule
